instr_memory_pipelined: RTL
===========================

# instr_memory_pipelined

Parametrised instruction memory for the MIPS pipeline, replacing the fixed 1K×32 combinational-read memory. Provides a byte-addressed fetch port with valid/ready handshake, registered 1-cycle read, backpressure hold, flush on redirect, and alignment/range fault reporting. A word-indexed load port fills the program image before or between fetch bursts. Sits between the PC/fetch stage and the IF/ID pipeline register.

## Interface
- DATA_W, 32: instruction width
- DEPTH, 1024: number of words; power of two, at least 2
- ADDR_W, 32: fetch PC width
- IDX_W, $clog2(DEPTH): word index width (derived)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ld_en  in  1  load-port write strobe
- ld_idx  in  IDX_W  word index to write
- ld_data  in  DATA_W  word to write
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request accepted this cycle
- req_pc  in  ADDR_W  byte address of the instruction
- flush  in  1  discard the pending response and block acceptance this cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_instr  out  DATA_W  fetched word; NOP (all zeros) on fault
- rsp_pc  out  ADDR_W  PC of the response
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range

## Operation
- req_ready = !ld_en && !flush && (!rsp_valid || rsp_ready); combinational.
- Accept: req_valid && req_ready at a rising edge. The response register captures the following:
  - rsp_pc = req_pc
  - rsp_fault from the checks below
  - rsp_instr = mem[req_pc[IDX_W+1:2]], or NOP on fault
- Fault priority:
  - Misaligned (req_pc[1:0] != 0) takes priority.
  - Out of range: req_pc[ADDR_W-1:IDX_W+2] != 0.
  - A faulted request still produces a response and does not read the array.
- rsp_valid update at each edge:
  - Set on accept.
  - Cleared on rsp_ready with no accept.
  - Held otherwise, with rsp_instr, rsp_pc and rsp_fault stable.
- flush has top priority. On a flush edge rsp_valid is cleared and nothing is accepted. rsp_instr, rsp_pc and rsp_fault keep their old values.
- Load: on an edge with ld_en, mem[ld_idx] = ld_data. Fetch is blocked that cycle, so there is no same-address read/write conflict. A pending response keeps its captured data even if that word is overwritten.
- Memory contents are not cleared by reset and persist across it. The loader is responsible for initialisation, and a simulation-only init file is optional.

## Timing
- Read latency is 1 cycle. A request accepted at edge N is visible on rsp_* after edge N.
- Throughput is 1 instruction per cycle while rsp_ready stays high.
- Backpressure: when rsp_valid && !rsp_ready, req_ready = 0 and outputs are frozen.
- Load visibility: a load at edge N is readable by a request accepted at edge N+1.
- Reset asserted, including mid-burst: immediately rsp_valid = 0, rsp_instr = 0, rsp_pc = 0, rsp_fault = 00. req_ready follows its equation, so it is 1 when ld_en and flush are low. The first accept is possible at the first edge after reset deasserts.
- Simultaneous events at one edge:
  - flush and accept: flush wins.
  - ld_en and req_valid: load wins and the request waits.
  - rsp_ready and accept: the old response retires and the new one is loaded.

## Structure
- Package imem_pkg holds the following:
  - the NOP constant
  - fault code localparams FAULT_OK, FAULT_MISALIGN, FAULT_RANGE
  - a 2-bit fault_t typedef
- Sub-module imem_array: DEPTH×DATA_W storage with one synchronous write port and one synchronous read port with read enable. No reset.
- Top level holds the handshake logic, the fault checks and the response register.

## Test plan
- Load mem[0..3] = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000, then fetch PCs 0, 4, 8, 12 back-to-back with rsp_ready = 1. Expect four consecutive responses carrying those words and their PCs, one per cycle, each 1 cycle after its accept.
- Fetch PC 0x6:
  - DEPTH=1024: expect rsp_fault = 01 and rsp_instr = 0.
  - DEPTH=16, PC 0x40: expect rsp_fault = 10.
- Accept PC 4, then hold rsp_ready = 0 for 3 cycles. Expect req_ready = 0 and outputs unchanged for those 3 cycles. Raise rsp_ready with req_valid high and PC 8: the next response appears 1 cycle later.
- Assert flush while rsp_valid = 1 and req_valid = 1. Expect rsp_valid = 0 after the edge and no accept that cycle. The request is accepted on the following edge.
- Drive ld_en with req_valid for 2 cycles. Expect req_ready = 0 for both cycles. Then fetch the just-loaded index and expect the new data.
- Pull rst low mid-burst. Expect all rsp_* outputs at 0 immediately, without waiting for a clock edge. After release, memory contents are retained: refetching PC 0 returns 0x20080001.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the pipelined instruction memory.
package imem_pkg;

  localparam int unsigned NOP_W = 32;

  // All-zeros word returned for any faulted fetch (sll $0,$0,0 on MIPS).
  localparam logic [NOP_W-1:0] NOP = '0;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_OK       = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_RANGE    = 2'b10;

  // Misalignment outranks the range check when both apply.
  function automatic fault_t fault_prio(input logic misalign, input logic out_of_range);
    fault_t f;
    f = FAULT_OK;
    if (misalign) begin
      f = FAULT_MISALIGN;
    end else if (out_of_range) begin
      f = FAULT_RANGE;
    end
    return f;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module imem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are deliberately not reset so the image survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register only updates on an enabled read, so it holds across stalls and loads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_memory_pipelined.sv
// Instruction memory with valid/ready fetch port, 1-cycle registered read,
// flush, alignment/range fault reporting and a word-indexed load port.
module instr_memory_pipelined
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_fault
);

  localparam int unsigned BYTE_SH = IDX_W + 2;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_pc_q,    rsp_pc_d;
  fault_t            rsp_fault_q, rsp_fault_d;
  logic              rsp_nop_q,   rsp_nop_d;

  logic              accept_c;
  logic              misalign_c;
  logic              out_of_range_c;
  fault_t            fault_c;
  logic              rd_en_c;
  logic [ADDR_W-1:0] pc_hi_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DATA_W-1:0] rd_data;

  // Handshake, fault classification and array read enable.
  always_comb begin
    req_ready      = !ld_en && !flush && (!rsp_valid_q || rsp_ready);
    accept_c       = req_valid && req_ready;
    misalign_c     = (req_pc[1:0] != 2'b00);
    pc_hi_c        = req_pc >> BYTE_SH;
    out_of_range_c = (pc_hi_c != '0);
    fault_c        = fault_prio(misalign_c, out_of_range_c);
    rd_en_c        = accept_c && (fault_c == FAULT_OK);
    rd_idx_c       = req_pc[IDX_W+1:2];
  end

  // Next-state for the response register: flush first, then accept, then retire.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    rsp_nop_d   = rsp_nop_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = req_pc;
      rsp_fault_d = fault_c;
      rsp_nop_d   = (fault_c != FAULT_OK);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response register; rsp_nop_q resets high so rsp_instr reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= FAULT_OK;
      rsp_nop_q   <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_nop_q   <= rsp_nop_d;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_idx),
    .wdata (ld_data),
    .re    (rd_en_c),
    .raddr (rd_idx_c),
    .rdata (rd_data)
  );

  // The read register itself has no reset; the NOP select masks it on fault/reset.
  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = rsp_nop_q ? DATA_W'(NOP) : rd_data;

endmodule
